// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and size decode for the load/store unit.
// Defining MISALIGNED_SPLIT_EN adds the second-beat states used by split accesses.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

`ifdef MISALIGNED_SPLIT_EN
   typedef enum logic [2:0] {StIdle, StAcc, StWait, StAcc2, StWait2, StResp} state_e;
`else
   typedef enum logic [2:0] {StIdle, StAcc, StWait, StResp} state_e;
`endif

   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         2'b10:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte strobes, write-data shifting, load capture merge
// and load extension. 'upper' selects the second (next doubleword) beat of a split access.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [2:0]  offset,
   input  logic        upper,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   input  logic [63:0] cap_in,
   output logic [7:0]  wstrb,
   output logic [63:0] wdata_lane,
   output logic [63:0] cap_out,
   output logic [63:0] ext_data
);

   logic [7:0]   size_mask;
   logic [5:0]   shamt;
   logic [15:0]  strb_wide;
   logic [127:0] wdata_wide;
   logic [63:0]  rdata_hi;

   assign shamt = {offset, 3'b000};

   always_comb begin
      case (funct3[1:0])
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   // Double-width shifts: low half is the first beat, high half spills into the second.
   assign strb_wide  = {8'h00, size_mask} << offset;
   assign wdata_wide = {64'h0, wdata} << shamt;
   assign rdata_hi   = 64'({rdata, 64'h0} >> shamt);

   assign wstrb      = upper ? strb_wide[15:8] : strb_wide[7:0];
   assign wdata_lane = upper ? wdata_wide[127:64] : wdata_wide[63:0];
   assign cap_out    = upper ? (cap_in | rdata_hi) : (rdata >> shamt);

   always_comb begin
      case (funct3)
         F3_B:    ext_data = {{56{cap_in[7]}}, cap_in[7:0]};
         F3_H:    ext_data = {{48{cap_in[15]}}, cap_in[15:0]};
         F3_W:    ext_data = {{32{cap_in[31]}}, cap_in[31:0]};
         F3_BU:   ext_data = {56'h0, cap_in[7:0]};
         F3_HU:   ext_data = {48'h0, cap_in[15:0]};
         F3_WU:   ext_data = {32'h0, cap_in[31:0]};
         default: ext_data = cap_in;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and data memory: one request in, aligned beats out,
// one response back. MISALIGNED_SPLIT_EN enables two-beat misaligned accesses.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_fault,
   output logic [63:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [7:0]  mem_wstrb,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
);

   state_e      state_q, state_d;
   logic        store_q, fault_q;
   logic [2:0]  f3_q;
   logic [63:0] addr_q, wdata_q, cap_q, cap_d;
   logic        accept, req_fault, upper, illegal;
   logic [7:0]  strb;
   logic [63:0] lane_wdata, cap_out, ext_data;

   assign accept  = req_valid && req_ready;
   assign illegal = (req_funct3 == 3'b111) || (req_store && req_funct3[2]);

`ifdef MISALIGNED_SPLIT_EN
   logic       split;
   logic [3:0] acc_end;
   assign acc_end   = {1'b0, addr_q[2:0]} + size_bytes(f3_q[1:0]);
   assign split     = acc_end > 4'd8;
   assign upper     = (state_q == StAcc2) || (state_q == StWait2);
   assign req_fault = illegal;
`else
   logic [2:0] size_m1;
   assign size_m1   = 3'(size_bytes(req_funct3[1:0]) - 4'd1);
   assign upper     = 1'b0;
   assign req_fault = illegal || (|(req_addr[2:0] & size_m1));
`endif

   lsu_align u_align (
      .funct3     (f3_q),
      .offset     (addr_q[2:0]),
      .upper      (upper),
      .wdata      (wdata_q),
      .rdata      (mem_rdata),
      .cap_in     (cap_q),
      .wstrb      (strb),
      .wdata_lane (lane_wdata),
      .cap_out    (cap_out),
      .ext_data   (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         store_q <= 1'b0;
         fault_q <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 64'h0;
         wdata_q <= 64'h0;
         cap_q   <= 64'h0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         if (accept) begin
            store_q <= req_store;
            fault_q <= req_fault;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cap_d     = cap_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 64'h0;
      case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) state_d = req_fault ? StResp : StAcc;
         end
         StAcc: begin
            mem_addr = {addr_q[63:3], 3'b000};
            if (store_q) begin
               mem_we  = 1'b1;
               state_d = StResp;
`ifdef MISALIGNED_SPLIT_EN
               if (split) state_d = StAcc2;
`endif
            end else begin
               mem_re  = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            cap_d   = cap_out;
            state_d = StResp;
`ifdef MISALIGNED_SPLIT_EN
            if (split) state_d = StAcc2;
`endif
         end
`ifdef MISALIGNED_SPLIT_EN
         StAcc2: begin
            mem_addr = {addr_q[63:3], 3'b000} + 64'd8;
            if (store_q) begin
               mem_we  = 1'b1;
               state_d = StResp;
            end else begin
               mem_re  = 1'b1;
               state_d = StWait2;
            end
         end
         StWait2: begin
            cap_d   = cap_out;
            state_d = StResp;
         end
`endif
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign mem_wstrb = mem_we ? strb : 8'h00;
   assign mem_wdata = mem_we ? lane_wdata : 64'h0;
   assign rsp_fault = rsp_valid && fault_q;
   assign rsp_data  = (rsp_valid && !store_q && !fault_q) ? ext_data : 64'h0;

endmodule
